register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register and data width in bits.
REQ-002 The block SHALL have parameter PC_IDX, default 15, giving the register index aliased to the program counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port RA1, input, 5 bits: read address for port 1 (Rn).
REQ-006 The block SHALL have port RA2, input, 5 bits: read address for port 2, as produced by the RegSrc-selected Rm/Rd mux.
REQ-007 The block SHALL have port RD1, output, DATA_W bits: read data for port 1.
REQ-008 The block SHALL have port RD2, output, DATA_W bits: read data for port 2.
REQ-009 The block SHALL have port WE3, input, 1 bit: writeback enable.
REQ-010 The block SHALL have port WA3, input, 5 bits: writeback address.
REQ-011 The block SHALL have port WD3, input, DATA_W bits: writeback data.
REQ-012 The block SHALL have port R15, input, DATA_W bits: PC+8 value returned for reads of PC_IDX.
REQ-013 The block SHALL have port Issue, input, 1 bit: the instruction in decode is issuing and will write IssueRd.
REQ-014 The block SHALL have port IssueRd, input, 5 bits: destination register of the issuing instruction.
REQ-015 The block SHALL have port Stall, output, 1 bit: a decode-stage operand is pending writeback.
REQ-016 The block SHALL have port Busy, output, 32 bits: the scoreboard, one bit per register.

Function
REQ-017 Storage SHALL be 32 registers x DATA_W bits, plus a 32-bit busy scoreboard.
REQ-018 Reads SHALL be combinational, with zero-cycle latency from RA1/RA2 to RD1/RD2.
REQ-019 A read of address PC_IDX SHALL return R15, regardless of stored contents or writeback.
REQ-020 Write bypass: when WE3=1, WA3=RAx and RAx≠PC_IDX, RDx SHALL equal WD3 in the same cycle.
REQ-021 When WE3=1 and WA3≠PC_IDX, register[WA3] SHALL take WD3 on the rising clk edge.
REQ-022 Writes with WA3=PC_IDX SHALL be discarded; the PC is owned by fetch.
REQ-023 Issue=1 with Stall=0 and IssueRd≠PC_IDX SHALL set busy[IssueRd] on the rising clk edge.
REQ-024 Issue=1 while Stall=1 SHALL have no effect on the scoreboard.
REQ-025 WE3=1 SHALL clear busy[WA3] on the rising clk edge.
REQ-026 If an issue (REQ-023) and WE3 target the same address in the same cycle, busy SHALL end set (issue wins) and the register SHALL still take WD3.
REQ-027 Stall SHALL be combinational and equal to OR over x in {1,2} of: busy[RAx], AND RAx≠PC_IDX, AND NOT (WE3 and WA3=RAx).
REQ-028 A writeback in the same cycle as a dependent read SHALL therefore resolve the hazard with no bubble.
REQ-029 Busy bit PC_IDX SHALL always read 0.
REQ-030 Busy SHALL reflect the registered scoreboard state only, with no same-cycle bypass.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear all 32 registers and all busy bits to 0.
REQ-032 During reset, RD1/RD2 SHALL follow the read rules over cleared storage (0, or R15 for PC_IDX), and Stall SHALL be 0.
REQ-033 During reset, Issue and WE3 SHALL be ignored.
REQ-034 Reset asserted mid-operation SHALL discard all pending busy bits with no writeback completion required.
REQ-035 Normal updates SHALL begin on the first rising clk edge after rst_n rises.

Verification
REQ-036 Write and read: write WD3=0xDEADBEEF to WA3=3; next cycle RA1=3 -> RD1=0xDEADBEEF.
REQ-037 Bypass: in the same cycle, WE3=1, WA3=7, WD3=0x12345678, RA2=7 -> RD2=0x12345678 combinationally.
REQ-038 PC alias: R15=0x108, write 0xFFFFFFFF to address 15, then RA1=15 -> RD1=0x108, Busy[15]=0.
REQ-039 Hazard: Issue with IssueRd=4; next cycle RA2=4 -> Stall=1. Later WE3=1, WA3=4 -> Stall=0 in that cycle, and Busy[4]=0 after the edge.
REQ-040 Collision: busy[5]=1; Issue=1, IssueRd=5 and WE3=1, WA3=5 in the same cycle (RA1/RA2 not 5) -> after the edge Busy[5]=1 and register 5=WD3.
REQ-041 Async reset: with Busy=0x00000030 and register 2=0xA5, drop rst_n between edges -> Busy=0 and RD1 (RA1=2)=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   32 x DATA_W general-purpose register file with two combinational read
//   ports, one writeback port and a per-register busy scoreboard used for
//   decode-stage hazard detection.
//
//   Register PC_IDX is not stored. Reads of it return R15 (PC+8 from fetch),
//   writes to it are dropped, and its busy bit is held at 0.
//
// Ports
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   RA1, RA2      : read addresses (Rn, and the RegSrc-selected Rm/Rd)
//   RD1, RD2      : read data, with a writeback bypass
//   WE3/WA3/WD3   : writeback enable / address / data
//   R15           : PC+8 value returned for reads of PC_IDX
//   Issue/IssueRd : decode is issuing an instruction that will write IssueRd
//   Stall         : a decode operand is still waiting on writeback
//   Busy          : registered scoreboard, one bit per register
// -----------------------------------------------------------------------------

// One register slot: its data word plus its scoreboard bit.
module register_file_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,    // take wd on this edge
  input  logic              set,   // an instruction targeting this slot issues
  input  logic              clr,   // writeback to this slot completes
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] q,
  output logic              busy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wr) q <= wd;
      // A new issue outranks a completing writeback to the same register:
      // the newer producer is still in flight.
      if (set)      busy <= 1'b1;
      else if (clr) busy <= 1'b0;
    end
  end

endmodule

module register_file #(
  parameter int DATA_W = 32,
  parameter int PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        RA1,
  input  logic [4:0]        RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE3,
  input  logic [4:0]        WA3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [DATA_W-1:0] R15,
  input  logic              Issue,
  input  logic [4:0]        IssueRd,
  output logic              Stall,
  output logic [31:0]       Busy
);

  localparam int         NREG = 32;
  localparam int         AW   = 5;
  localparam logic [4:0] PC_A = AW'(PC_IDX);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy_q;

  // Writeback is ignored while reset is held. Storage is already held in
  // reset, so this gate matters only for the read bypass and hazard terms.
  logic we_ok;
  assign we_ok = WE3 & rst_n;

  // Hazard on one read port. A writeback landing this cycle resolves it,
  // because the bypass supplies the value. The PC alias never stalls.
  function automatic logic hazard(input logic [AW-1:0] ra);
    return busy_q[ra] && (ra != PC_A) && !(we_ok && (WA3 == ra));
  endfunction

  // Read one port. The PC alias comes first and the writeback bypass second,
  // so the bypass never overrides R15.
  function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] ra);
    if (ra == PC_A)               return R15;
    else if (we_ok && WA3 == ra)  return WD3;
    else                          return regs[ra];
  endfunction

  always_comb begin
    RD1   = rd_port(RA1);
    RD2   = rd_port(RA2);
    Stall = hazard(RA1) | hazard(RA2);
  end

  // An issue that is itself stalled, or that targets the PC, leaves the
  // scoreboard unchanged.
  logic issue_ok;
  assign issue_ok = Issue && !Stall && (IssueRd != PC_A);

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_reg
      if (i == PC_IDX) begin : g_pc
        // The PC slot has no storage. Its data comes from R15 on read.
        assign regs[i]   = '0;
        assign busy_q[i] = 1'b0;
      end else begin : g_gpr
        logic hit_wa;
        assign hit_wa = we_ok && (WA3 == AW'(i));

        register_file_entry #(.DATA_W(DATA_W)) u_entry (
          .clk   (clk),
          .rst_n (rst_n),
          .wr    (hit_wa),
          .set   (issue_ok && (IssueRd == AW'(i))),
          .clr   (hit_wa),
          .wd    (WD3),
          .q     (regs[i]),
          .busy  (busy_q[i])
        );
      end
    end
  endgenerate

  // Busy shows the registered scoreboard only, with no same-cycle bypass.
  assign Busy = busy_q;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed-vector bench for register_file. Expected values are hand-computed
//   constants. Outputs are sampled #1 after input changes or after a clock
//   edge, never on the edge itself.
// -----------------------------------------------------------------------------
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  RA1, RA2, WA3, IssueRd;
  logic [31:0] RD1, RD2, WD3, R15;
  logic        WE3, Issue, Stall;
  logic [31:0] Busy;

  int vectors     = 0;
  int miscompares = 0;

  register_file #(.DATA_W(32), .PC_IDX(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RA1     (RA1),
    .RA2     (RA2),
    .RD1     (RD1),
    .RD2     (RD2),
    .WE3     (WE3),
    .WA3     (WA3),
    .WD3     (WD3),
    .R15     (R15),
    .Issue   (Issue),
    .IssueRd (IssueRd),
    .Stall   (Stall),
    .Busy    (Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; Issue = 1'b0; WA3 = '0; WD3 = '0; IssueRd = '0;
  endtask

  initial begin
    rst_n = 1'b0; R15 = 32'h108;
    RA1 = 5'd0; RA2 = 5'd15;
    idle();
    #1;
    // Reset state: storage cleared, PC alias still reads R15.
    chk("rst_busy",   Busy,  32'h0);
    chk("rst_rd1",    RD1,   32'h0);
    chk("rst_rd2_pc", RD2,   32'h108);
    chk("rst_stall",  {31'b0, Stall}, 32'h0);

    // Writeback and issue presented during reset are ignored.
    WE3 = 1'b1; WA3 = 5'd3; WD3 = 32'hCAFE; Issue = 1'b1; IssueRd = 5'd9; RA1 = 5'd3;
    #1 chk("rst_no_bypass", RD1, 32'h0);
    tick();
    chk("rst_no_write", RD1,  32'h0);
    chk("rst_no_issue", Busy, 32'h0);
    idle();
    rst_n = 1'b1;                     // released between edges

    // Write, then read next cycle.
    WE3 = 1'b1; WA3 = 5'd3; WD3 = 32'hDEADBEEF;
    tick();
    idle(); RA1 = 5'd3;
    #1 chk("wr_rd", RD1, 32'hDEADBEEF);

    // Same-cycle bypass on port 2.
    WE3 = 1'b1; WA3 = 5'd7; WD3 = 32'h12345678; RA2 = 5'd7;
    #1 chk("bypass", RD2, 32'h12345678);
    tick();
    idle();
    #1 chk("bypass_stored", RD2, 32'h12345678);

    // PC alias: no bypass, write discarded, issue to the PC does nothing.
    WE3 = 1'b1; WA3 = 5'd15; WD3 = 32'hFFFFFFFF; RA1 = 5'd15;
    Issue = 1'b1; IssueRd = 5'd15;
    #1 chk("pc_no_bypass", RD1, 32'h108);
    tick();
    idle();
    #1 chk("pc_read", RD1,  32'h108);
    chk("pc_busy",    Busy, 32'h0);

    // Hazard: issue r4, then a read of r4 stalls.
    RA1 = 5'd0; RA2 = 5'd0;
    Issue = 1'b1; IssueRd = 5'd4;
    tick();
    idle();
    chk("issue_busy", Busy, 32'h10);
    RA2 = 5'd4;
    #1 chk("hazard_stall", {31'b0, Stall}, 32'h1);
    // An issue made while stalled leaves the scoreboard alone.
    Issue = 1'b1; IssueRd = 5'd6;
    tick();
    Issue = 1'b0;
    chk("stalled_issue", Busy, 32'h10);
    // Writeback of r4 resolves the hazard in the same cycle.
    WE3 = 1'b1; WA3 = 5'd4; WD3 = 32'h44;
    #1 chk("wb_no_stall", {31'b0, Stall}, 32'h0);
    chk("wb_bypass", RD2, 32'h44);
    tick();
    idle();
    chk("wb_clear", Busy, 32'h0);

    // Collision: issue and writeback to r5 in the same cycle.
    RA1 = 5'd0; RA2 = 5'd1;
    Issue = 1'b1; IssueRd = 5'd5;
    tick();
    chk("busy5", Busy, 32'h20);
    Issue = 1'b1; IssueRd = 5'd5; WE3 = 1'b1; WA3 = 5'd5; WD3 = 32'h55;
    #1 chk("coll_no_stall", {31'b0, Stall}, 32'h0);
    tick();
    idle();
    chk("coll_busy", Busy, 32'h20);
    RA1 = 5'd5;
    #1 chk("coll_data", RD1, 32'h55);

    // Build Busy=0x30 and r2=0xA5 for the async reset check.
    RA1 = 5'd0;
    Issue = 1'b1; IssueRd = 5'd4; WE3 = 1'b1; WA3 = 5'd2; WD3 = 32'hA5;
    tick();
    idle();
    chk("pre_rst_busy", Busy, 32'h30);
    RA1 = 5'd2; RA2 = 5'd5;
    #1 chk("pre_rst_rd1",   RD1, 32'hA5);
    chk("pre_rst_stall", {31'b0, Stall}, 32'h1);

    // Drop reset between edges; the effect must be immediate.
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy",  Busy, 32'h0);
    chk("async_rd1",   RD1,  32'h0);
    chk("async_stall", {31'b0, Stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // The first edge after reset release performs updates.
    WE3 = 1'b1; WA3 = 5'd8; WD3 = 32'h88; Issue = 1'b1; IssueRd = 5'd9; RA1 = 5'd0; RA2 = 5'd0;
    tick();
    idle(); RA1 = 5'd8;
    #1 chk("post_rst_wr",   RD1,  32'h88);
    chk("post_rst_issue", Busy, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
